// File: rtl/bus_fifo_pkg.sv
// Shared types and helpers for the bus port FIFO pair.
// Used by sync_fifo_fwft and bus_port_fifo (see BUS_PORT_FIFO_STATS_EN in the top).
package bus_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fifo_state_e;

    localparam int unsigned OVF_TX = 0;
    localparam int unsigned OVF_RX = 1;

    // Pointer advance that wraps at depth-1, so non-power-of-2 depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with sticky overflow flag.
// Output reads 0 when empty; push while full is accepted only if a pop happens the same cycle.
module sync_fifo_fwft
    import bus_fifo_pkg::*;
#(
    parameter int unsigned pckg_sz = 4,
    parameter int unsigned depth   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [pckg_sz-1:0]         din,
    input  logic                       rd,
    output logic [pckg_sz-1:0]         dout,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CntW = $clog2(depth + 1);

    logic [pckg_sz-1:0] mem [depth];
    logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]    count_q;
    logic               ovf_q;
    fifo_state_e        state;
    logic               do_rd, do_wr;

    always_comb begin
        state = PARTIAL;
        if (count_q == '0) begin
            state = EMPTY;
        end else if (count_q == CntW'(depth)) begin
            state = FULL;
        end
    end

    assign empty = (state == EMPTY);
    assign full  = (state == FULL);

    // A pop frees the slot, so a simultaneous push into a full FIFO still lands.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= PtrW'(ptr_inc(32'(wr_ptr_q), depth));
            end
            if (do_rd) begin
                rd_ptr_q <= PtrW'(ptr_inc(32'(rd_ptr_q), depth));
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
            if (wr && full && !rd) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr_q];
    assign ovf   = ovf_q;
    assign count = count_q;

endmodule

// File: rtl/bus_port_fifo.sv
// TX/RX FIFO pair between a device and one bus port.
// Define BUS_PORT_FIFO_STATS_EN to add accepted/dropped packet counters.
module bus_port_fifo
    import bus_fifo_pkg::*;
#(
    parameter int unsigned pckg_sz = 4,
    parameter int unsigned depth   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dev_push,
    input  logic [pckg_sz-1:0] dev_din,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               dev_pop,
    output logic [pckg_sz-1:0] dev_dout,
    output logic               rx_pndng,
`ifdef BUS_PORT_FIFO_STATS_EN
    output logic [15:0]        tx_cnt_total,
    output logic [15:0]        rx_cnt_total,
    output logic [7:0]         drop_cnt,
`endif
    output logic [1:0]         ovf
);

    localparam int unsigned CntW = $clog2(depth + 1);

    logic            tx_empty, rx_empty, rx_full;
    logic            tx_ovf, rx_ovf;
    logic [CntW-1:0] tx_count, rx_count;

    sync_fifo_fwft #(
        .pckg_sz (pckg_sz),
        .depth   (depth)
    ) tx_fifo_i (
        .clk   (clk),
        .reset (reset),
        .wr    (dev_push),
        .din   (dev_din),
        .rd    (pop),
        .dout  (D_pop),
        .empty (tx_empty),
        .full  (tx_full),
        .ovf   (tx_ovf),
        .count (tx_count)
    );

    sync_fifo_fwft #(
        .pckg_sz (pckg_sz),
        .depth   (depth)
    ) rx_fifo_i (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .din   (D_push),
        .rd    (dev_pop),
        .dout  (dev_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .ovf   (rx_ovf),
        .count (rx_count)
    );

    assign pndng       = !tx_empty;
    assign rx_pndng    = !rx_empty;
    assign ovf[OVF_TX] = tx_ovf;
    assign ovf[OVF_RX] = rx_ovf;

`ifdef BUS_PORT_FIFO_STATS_EN
    logic        tx_acc, rx_acc, tx_drop, rx_drop;
    logic [15:0] tx_tot_q, rx_tot_q;
    logic [7:0]  drop_q;
    logic [8:0]  drop_sum;

    // Mirrors the FIFO accept rule: a full FIFO takes a push only alongside a pop.
    assign tx_acc  = dev_push && ((tx_count != CntW'(depth)) || (pop && tx_count != '0));
    assign rx_acc  = push && ((rx_count != CntW'(depth)) || (dev_pop && rx_count != '0));
    assign tx_drop = dev_push && tx_full && !pop;
    assign rx_drop = push && rx_full && !dev_pop;

    assign drop_sum = {1'b0, drop_q} + 9'(tx_drop) + 9'(rx_drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_tot_q <= '0;
            rx_tot_q <= '0;
            drop_q   <= '0;
        end else begin
            tx_tot_q <= tx_tot_q + 16'(tx_acc);
            rx_tot_q <= rx_tot_q + 16'(rx_acc);
            drop_q   <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    assign tx_cnt_total = tx_tot_q;
    assign rx_cnt_total = rx_tot_q;
    assign drop_cnt     = drop_q;
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// Bench for bus_port_fifo: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_bus_port_fifo;

    localparam int unsigned PSZ   = 4;
    localparam int unsigned DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           dev_push, pop, push, dev_pop;
    logic [PSZ-1:0] dev_din, D_push;
    logic           tx_full, pndng, rx_pndng;
    logic [PSZ-1:0] D_pop, dev_dout;
    logic [1:0]     ovf;
`ifdef BUS_PORT_FIFO_STATS_EN
    logic [15:0]    tx_cnt_total, rx_cnt_total;
    logic [7:0]     drop_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    bus_port_fifo #(
        .pckg_sz (PSZ),
        .depth   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dev_push     (dev_push),
        .dev_din      (dev_din),
        .tx_full      (tx_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .dev_pop      (dev_pop),
        .dev_dout     (dev_dout),
        .rx_pndng     (rx_pndng),
`ifdef BUS_PORT_FIFO_STATS_EN
        .tx_cnt_total (tx_cnt_total),
        .rx_cnt_total (rx_cnt_total),
        .drop_cnt     (drop_cnt),
`endif
        .ovf          (ovf)
    );

    // Reference model: plain queues applying the accept/drop rules per edge.
    logic [PSZ-1:0] txq[$];
    logic [PSZ-1:0] rxq[$];
    logic [1:0]     m_ovf;
    logic [15:0]    m_tx_tot, m_rx_tot;
    int             m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_ovf    = 2'b00;
            m_tx_tot = 16'd0;
            m_rx_tot = 16'd0;
            m_drop   = 0;
        end else begin
            bit tx_popped, rx_popped;
            tx_popped = pop && (txq.size() > 0);
            rx_popped = dev_pop && (rxq.size() > 0);
            if (tx_popped) void'(txq.pop_front());
            if (rx_popped) void'(rxq.pop_front());
            if (dev_push) begin
                if (txq.size() < DEPTH) begin
                    txq.push_back(dev_din);
                    m_tx_tot = m_tx_tot + 16'd1;
                end else begin
                    m_ovf[0] = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (push) begin
                if (rxq.size() < DEPTH) begin
                    rxq.push_back(D_push);
                    m_rx_tot = m_rx_tot + 16'd1;
                end else begin
                    m_ovf[1] = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pndng", 32'(pndng), 32'(txq.size() != 0));
            chk("m_D_pop", 32'(D_pop), (txq.size() != 0) ? 32'(txq[0]) : 32'd0);
            chk("m_tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
            chk("m_rx_pndng", 32'(rx_pndng), 32'(rxq.size() != 0));
            chk("m_dev_dout", 32'(dev_dout), (rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
`ifdef BUS_PORT_FIFO_STATS_EN
            chk("m_tx_cnt_total", 32'(tx_cnt_total), 32'(m_tx_tot));
            chk("m_rx_cnt_total", 32'(rx_cnt_total), 32'(m_rx_tot));
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        end
    end

    task automatic cyc(input logic dp, input logic [PSZ-1:0] di, input logic p,
                       input logic bp, input logic [PSZ-1:0] bd, input logic dpo);
        dev_push = dp;
        dev_din  = di;
        pop      = p;
        push     = bp;
        D_push   = bd;
        dev_pop  = dpo;
        @(posedge clk);
        #1;
        dev_push = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        dev_pop  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        dev_push = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        dev_pop  = 1'b0;
        dev_din  = '0;
        D_push   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // 1: reset state, single push/pop
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_D_pop", 32'(D_pop), 0);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_pndng", 32'(rx_pndng), 0);
        chk("rst_dev_dout", 32'(dev_dout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        cyc(1, 4'h3, 0, 0, 0, 0);
        chk("t1_pndng", 32'(pndng), 1);
        chk("t1_D_pop", 32'(D_pop), 32'h3);
        chk("t1_tx_full", 32'(tx_full), 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t1_pndng_after_pop", 32'(pndng), 0);
        chk("t1_D_pop_after_pop", 32'(D_pop), 0);

        // 2: fill, overflow, ordered drain
        for (int i = 1; i <= 8; i++) cyc(1, PSZ'(i), 0, 0, 0, 0);
        chk("t2_tx_full", 32'(tx_full), 1);
        cyc(1, 4'hF, 0, 0, 0, 0);
        chk("t2_ovf", 32'(ovf), 32'b01);
`ifdef BUS_PORT_FIFO_STATS_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 1);
`endif
        for (int i = 1; i <= 8; i++) begin
            chk("t2_order", 32'(D_pop), 32'(i));
            cyc(0, 0, 1, 0, 0, 0);
        end
        chk("t2_empty", 32'(pndng), 0);

        // 3: push+pop while full
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, PSZ'(i), 0, 0, 0, 0);
        cyc(1, 4'hA, 1, 0, 0, 0);
        chk("t3_full", 32'(tx_full), 1);
        chk("t3_ovf", 32'(ovf), 0);
        for (int i = 2; i <= 8; i++) begin
            chk("t3_order", 32'(D_pop), 32'(i));
            cyc(0, 0, 1, 0, 0, 0);
        end
        chk("t3_last", 32'(D_pop), 32'hA);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t3_empty", 32'(pndng), 0);

        // 4: push+pop while empty
        cyc(1, 4'h5, 1, 0, 0, 0);
        chk("t4_pndng", 32'(pndng), 1);
        chk("t4_D_pop", 32'(D_pop), 32'h5);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t4_count1", 32'(pndng), 0);

        // 5: RX path alongside TX traffic
        cyc(1, 4'h9, 0, 1, 4'h6, 0);
        cyc(0, 0, 0, 1, 4'h7, 0);
        chk("t5_rx_pndng", 32'(rx_pndng), 1);
        chk("t5_dev_dout", 32'(dev_dout), 32'h6);
        chk("t5_tx_head", 32'(D_pop), 32'h9);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_dev_dout2", 32'(dev_dout), 32'h7);
        cyc(0, 0, 1, 0, 0, 1);
        chk("t5_rx_empty", 32'(rx_pndng), 0);
        chk("t5_tx_empty", 32'(pndng), 0);

        // 6: asynchronous reset mid-cycle
        for (int i = 1; i <= 5; i++) cyc(1, PSZ'(i), 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_pndng_async", 32'(pndng), 0);
        chk("t6_D_pop_async", 32'(D_pop), 0);
        @(posedge clk);
        #1 reset = 1'b1;
`ifdef BUS_PORT_FIFO_STATS_EN
        chk("t6_tx_cnt_total", 32'(tx_cnt_total), 0);
`endif
        cyc(1, 4'h2, 0, 0, 0, 0);
        chk("t6_D_pop", 32'(D_pop), 32'h2);
        chk("t6_pndng", 32'(pndng), 1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t6_count1", 32'(pndng), 0);

        // Randomized traffic with alternating fill/drain bias
        for (int k = 0; k < 3000; k++) begin
            int bias;
            bias = ((k / 150) % 2 == 1) ? 75 : 30;
            cyc($urandom_range(0, 99) < bias, PSZ'($urandom),
                $urandom_range(0, 99) < (100 - bias),
                $urandom_range(0, 99) < (105 - bias), PSZ'($urandom),
                $urandom_range(0, 99) < bias - 5);
            if (k == 1700) do_reset();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
